// File: rtl/shift_exec_stage_if.sv
// Request/result handshake bundle for the execute-stage shifter.
// master drives requests and accepts results; slave is the stage.
interface shift_exec_stage_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic [4:0]   in_shamt;
  logic [1:0]   in_op;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic         out_illegal;

  modport master (
    output in_valid, in_data, in_shamt, in_op, out_ready,
    input  in_ready, out_valid, out_data, out_illegal
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_op, out_ready,
    output in_ready, out_valid, out_data, out_illegal
  );
endinterface

// File: rtl/shift_exec_stage.sv
// Two-stage elastic SLL/SRL/SRA unit built around one left shifter.
// Right shifts run as bit-reverse, shift left, bit-reverse.
module shift_exec_stage #(
  parameter int N = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  shift_exec_stage_if.slave io
);
  localparam int SW = $clog2(N);

  function automatic logic [N-1:0] f_rev(
    input logic [N-1:0] a
  );
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = a[N-1-i];
    return r;
  endfunction

  function automatic logic [N-1:0] f_sll(
    input logic [N-1:0]  a,
    input logic [SW-1:0] s
  );
    return a << s;
  endfunction

  logic          r_a_valid;
  logic [N-1:0]  r_a_data;
  logic [SW-1:0] r_a_shamt;
  logic [1:0]    r_a_op;
  logic          r_b_valid;
  logic [N-1:0]  r_b_data;
  logic          r_b_ill;

  logic          w_b_load;
  logic          w_a_load;
  logic          w_op_sll;
  logic          w_op_srl;
  logic          w_op_sra;
  logic [N-1:0]  w_core_in;
  logic [N-1:0]  w_core;
  logic [N-1:0]  w_srl;
  logic [N-1:0]  w_fill;
  logic [N-1:0]  w_res;
  logic          w_ill;

  assign w_b_load = !r_b_valid || io.out_ready;
  assign io.in_ready = rst_n && (!r_a_valid || w_b_load);
  assign w_a_load = io.in_valid && io.in_ready;

  assign w_op_sll = (r_a_op == 2'b00);
  assign w_op_srl = (r_a_op == 2'b01);
  assign w_op_sra = (r_a_op == 2'b11);

  assign w_core_in = w_op_sll ? r_a_data : f_rev(r_a_data);
  assign w_core = f_sll(w_core_in, r_a_shamt);
  assign w_srl = f_rev(w_core);
  // Top shamt bits set: these are the positions SRA must sign-fill.
  assign w_fill = ~f_rev(f_sll({N{1'b1}}, r_a_shamt))
                & {N{r_a_data[N-1]}};

  always_comb begin
    w_res = '0;
    w_ill = 1'b0;
    unique case (1'b1)
      w_op_sll: w_res = w_core;
      w_op_srl: w_res = w_srl;
      w_op_sra: w_res = w_srl | w_fill;
      default:  w_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a_valid <= 1'b0;
      r_a_data  <= '0;
      r_a_shamt <= '0;
      r_a_op    <= '0;
      r_b_valid <= 1'b0;
      r_b_data  <= '0;
      r_b_ill   <= 1'b0;
    end else begin
      if (w_a_load) begin
        r_a_data  <= io.in_data;
        r_a_shamt <= io.in_shamt;
        r_a_op    <= io.in_op;
      end
      if (w_a_load) r_a_valid <= 1'b1;
      else if (w_b_load) r_a_valid <= 1'b0;
      if (w_b_load) begin
        r_b_valid <= r_a_valid;
        if (r_a_valid) begin
          r_b_data <= w_res;
          r_b_ill  <= w_ill;
        end
      end
    end
  end

  assign io.out_valid   = r_b_valid;
  assign io.out_data    = r_b_data;
  assign io.out_illegal = r_b_ill;
endmodule

// File: tb/tb_shift_exec_stage.sv
// Directed and soak bench for shift_exec_stage.
// Scoreboard queue tracks every accepted request in order.
module tb_shift_exec_stage;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  int   cyc;

  shift_exec_stage_if #(.N(32)) bus ();

  shift_exec_stage #(.N(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        ill;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t        q[$];
  logic [31:0] p_data;
  logic        p_ill;
  bit          p_lat;
  bit          soak_done;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cyc %0d",
               tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model(
    input logic [31:0] d,
    input logic [4:0]  s,
    input logic [1:0]  op
  );
    case (op)
      2'b00:   return d << s;
      2'b01:   return d >> s;
      2'b11:   return 32'($signed(d) >>> s);
      default: return 32'h0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("out_data", bus.out_data, e.data);
          chk("out_ill", {31'd0, bus.out_illegal}, {31'd0, e.ill});
          if (e.lat) chk("latency", cyc - e.cyc, 32'd2);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_t e;
        e.data = p_data;
        e.ill  = p_ill;
        e.cyc  = cyc;
        e.lat  = p_lat;
        q.push_back(e);
      end
    end
  end

  task automatic send(
    input logic [31:0] d,
    input logic [4:0]  s,
    input logic [1:0]  op,
    input logic [31:0] ed,
    input logic        ei,
    input bit          lat
  );
    bit acc;
    bus.in_data  = d;
    bus.in_shamt = s;
    bus.in_op    = op;
    p_data       = ed;
    p_ill        = ei;
    p_lat        = lat;
    bus.in_valid = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      acc = bus.in_ready && rst_n;
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && q.size() != 0; k++) begin
      @(negedge clk);
      #1;
    end
    chk("drain", q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    cyc = 0;
    soak_done = 1'b0;
    p_data = '0;
    p_ill = 1'b0;
    p_lat = 1'b0;
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 32'hA5A5_A5A5;
    bus.in_shamt = 5'd3;
    bus.in_op = 2'b00;
    bus.out_ready = 1'b1;

    @(posedge clk);
    repeat (2) begin
      @(negedge clk);
      chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_out_data", bus.out_data, 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("post_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    repeat (3) @(posedge clk);
    #1;

    send(32'h8000_00F1, 5'd4, 2'b00, 32'h0000_0F10, 1'b0, 1'b1);
    send(32'h8000_00F1, 5'd4, 2'b01, 32'h0800_000F, 1'b0, 1'b1);
    send(32'h8000_00F1, 5'd4, 2'b11, 32'hF800_000F, 1'b0, 1'b1);
    drain();

    send(32'hDEAD_BEEF, 5'd0, 2'b00, 32'hDEAD_BEEF, 1'b0, 1'b1);
    send(32'hDEAD_BEEF, 5'd0, 2'b01, 32'hDEAD_BEEF, 1'b0, 1'b1);
    send(32'hDEAD_BEEF, 5'd0, 2'b11, 32'hDEAD_BEEF, 1'b0, 1'b1);
    send(32'h8000_0001, 5'd31, 2'b00, 32'h8000_0000, 1'b0, 1'b1);
    send(32'h8000_0001, 5'd31, 2'b01, 32'h0000_0001, 1'b0, 1'b1);
    send(32'h8000_0001, 5'd31, 2'b11, 32'hFFFF_FFFF, 1'b0, 1'b1);
    drain();

    send(32'h1234_5678, 5'd7, 2'b10, 32'h0000_0000, 1'b1, 1'b1);
    send(32'h0000_0001, 5'd1, 2'b00, 32'h0000_0002, 1'b0, 1'b1);
    drain();

    fork
      begin
        send(32'h0000_0011, 5'd1, 2'b00, 32'h0000_0022, 1'b0, 1'b0);
        send(32'h0000_0100, 5'd4, 2'b01, 32'h0000_0010, 1'b0, 1'b0);
        send(32'hF000_0000, 5'd8, 2'b11, 32'hFFF0_0000, 1'b0, 1'b0);
        send(32'h0F00_0000, 5'd8, 2'b11, 32'h000F_0000, 1'b0, 1'b0);
        send(32'h0000_0003, 5'd30, 2'b00, 32'hC000_0000, 1'b0, 1'b0);
        send(32'h5555_5555, 5'd2, 2'b10, 32'h0000_0000, 1'b1, 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
          chk("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
          chk("stall_out_data", bus.out_data,
              (q.size() > 0) ? q[0].data : 32'hxxxx_xxxx);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    bus.out_ready = 1'b0;
    send(32'h0000_00FF, 5'd4, 2'b00, 32'h0000_0FF0, 1'b0, 1'b0);
    send(32'h0000_00FF, 5'd4, 2'b01, 32'h0000_000F, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    repeat (3) begin
      @(negedge clk);
      chk("midrst_quiet", {31'd0, bus.out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    send(32'h8765_4321, 5'd16, 2'b11, 32'hFFFF_8765, 1'b0, 1'b1);
    drain();

    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          logic [31:0] d;
          logic [4:0]  s;
          logic [1:0]  op;
          d  = $urandom;
          s  = 5'($urandom_range(0, 31));
          op = 2'($urandom_range(0, 3));
          while ($urandom_range(0, 9) < 3) begin
            @(posedge clk);
            #1;
          end
          send(d, s, op, model(d, s, op), (op == 2'b10), 1'b0);
        end
        soak_done = 1'b1;
      end
      begin
        while (!soak_done) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 9) < 7);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/shift_exec_stage.md
Name: shift_exec_stage

Overview:
- Pipelined execute-stage shift unit for the ALU datapath.
- Accepts one operand, shift amount and shift op per handshake, and produces SLL, SRL or SRA results two cycles later.
- Wraps the team's combinational 32-bit logical left shifter. Right shifts are performed by bit-reversing the operand, left-shifting, and bit-reversing the result, so only one shifter core is needed.
- Sits between the operand-select/decode logic (upstream) and the ALU result mux/writeback register (downstream).

Parameters:
- N, 32, datapath width. Only 32 is supported; it sets shamt width to $clog2(N) = 5.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- in_valid  input  1  upstream presents a valid request.
- in_ready  output  1  stage can accept a request this cycle.
- in_data  input  N  operand to shift.
- in_shamt  input  5  shift amount, 0..31.
- in_op  input  2  00 = SLL, 01 = SRL, 11 = SRA, 10 = illegal.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result this cycle.
- out_data  output  N  shift result.
- out_illegal  output  1  result came from op 10.

Behaviour:
- Reset: rst_n sampled low at a rising edge clears all state.
  - Stage A valid = 0; out_valid = 0; out_data = 0; out_illegal = 0.
  - in_ready forced 0 in any cycle where rst_n = 0.
  - Reset mid-operation discards all in-flight requests; nothing is emitted for them.
- Handshakes:
  - Transfer occurs when valid && ready on the same edge.
  - Upstream inputs are sampled only on the accepting edge.
  - in_ready does not depend combinationally on in_valid.
- Pipeline: two registered stages, A (operand capture) and B (output register).
  - Edge 1 (accept): data, shamt and op captured into A.
  - Between A and B: shift computed combinationally.
  - Edge 2: result loaded into B. out_valid rises the cycle after edge 2.
  - Minimum latency is 2 cycles from acceptance to out_valid.
- Elastic stall rules:
  - B loads when B is empty, or when out_valid && out_ready.
  - A advances into B whenever B loads.
  - in_ready = !A_valid || B loads this cycle.
  - Sustained throughput is 1 result per cycle with out_ready held high.
  - With both stages full and out_ready = 0: in_ready = 0, and out_data/out_illegal hold stable.
  - Simultaneous drain of B, advance of A, and accept into A on the same edge is required and must lose nothing.
- Arithmetic (N = 32, shamt s):
  - SLL: in << s, zero fill.
  - SRL: in >> s, zero fill. Realised as rev(sll(rev(in), s)).
  - SRA: SRL result, with the top s bits set to in[31]. The fill mask is rev(sll(rev(all-ones), s)) inverted, ANDed with the sign.
  - s = 0 returns the operand unchanged for all ops.
  - s = 31 leaves a single significant bit.
  - Shifts of 32 or more are not representable.
- Illegal op 10: out_data = 0 and out_illegal = 1. Handshake timing is unchanged; the request flows like any other.
- Ordering: results emerge strictly in acceptance order. No reordering, no drops, no duplicates.

Test Plan:
- Reset then idle: rst_n low for 2 cycles with in_valid = 1 -> in_ready = 0, out_valid = 0, out_data = 0. After release, in_ready = 1 and no spurious out_valid.
- Basic ops, out_ready = 1, in_data = 0x8000_00F1, shamt = 4:
  - SLL -> 0x0000_0F10
  - SRL -> 0x0800_000F
  - SRA -> 0xF800_000F
  - Each appears exactly 2 cycles after acceptance, back-to-back on consecutive cycles.
- Boundaries:
  - shamt = 0 on 0xDEAD_BEEF returns 0xDEAD_BEEF for all ops.
  - shamt = 31 on 0x8000_0001: SLL -> 0x8000_0000, SRL -> 0x0000_0001, SRA -> 0xFFFF_FFFF.
- Backpressure:
  - Stream 6 requests; hold out_ready = 0 for 5 cycles mid-stream -> in_ready drops after 2 buffered, out_data stable throughout.
  - On release, all 6 results arrive in order with none lost or duplicated.
  - Random out_ready/in_valid soak of 10k requests matches a reference model.
- Illegal op 10 with in_data = 0x1234_5678 -> out_data = 0, out_illegal = 1. The next legal request's out_illegal = 0.
- Reset mid-flight: accept 2 requests, assert rst_n low 1 cycle before the first would emerge -> neither result appears. A post-reset request completes normally with 2-cycle latency.
